// File: rtl/move_word_assembler.sv
// Parses 4-word coordinated-move commands from the SPI word stream into a DEPTH-entry move queue, passing other words through.
// Latency: a queued move is visible one cycle after its last word. The executor pops with move_valid/move_ready; a full queue drops new moves and sets overflow_err.
module move_word_assembler #(
  parameter int          DEPTH    = 4,
  parameter logic [7:0]  CMD_MOVE = 8'h01
) (
  input  logic                     CLK,
  input  logic                     resetn,
  input  logic                     word_valid,
  input  logic [63:0]              word_data,
  input  logic [63:0]              encoder_count,
  input  logic                     halt,
  input  logic                     clear_err,
  output logic [63:0]              reply_data,
  output logic                     pass_valid,
  output logic [63:0]              pass_data,
  output logic                     move_valid,
  input  logic                     move_ready,
  output logic                     move_dir,
  output logic [63:0]              move_duration,
  output logic [63:0]              move_increment,
  output logic [63:0]              move_incinc,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     buffer_dtr,
  output logic                     overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

  typedef struct packed {
    logic        dir;
    logic [63:0] dur;
    logic [63:0] inc;
    logic [63:0] incinc;
  } move_t;

  typedef enum logic [1:0] {IDLE, DUR, INC, INCINC} state_t;

  state_t        state;
  logic          dir_q;
  logic [63:0]   dur_q;
  logic [63:0]   inc_q;
  logic [63:0]   enc_snap;
  move_t         mem [DEPTH];
  move_t         head_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          accept;
  logic          push_req;
  logic          full;
  logic          pop;
  logic          push;
  logic [PW-1:0] rd_ptr_n;
  logic [CW-1:0] remain;
  logic [CW-1:0] count_n;
  move_t         new_entry;

  always_comb begin
    accept    = word_valid && !halt;
    push_req  = accept && (state == INCINC);
    full      = (fifo_count == DEPTH_CNT);
    pop       = move_valid && move_ready && !halt;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    push      = push_req && (!full || pop);
    rd_ptr_n  = rd_ptr + PW'(pop);
    remain    = fifo_count - CW'(pop);
    count_n   = remain + CW'(push);
    new_entry = '{dir: dir_q, dur: dur_q, inc: inc_q, incinc: word_data};
  end

  always_ff @(posedge CLK) begin
    if (resetn && push)
      mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state        <= IDLE;
      dir_q        <= 1'b0;
      dur_q        <= '0;
      inc_q        <= '0;
      enc_snap     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      head_q       <= '0;
      reply_data   <= '0;
      pass_valid   <= 1'b0;
      pass_data    <= '0;
      overflow_err <= 1'b0;
    end else begin
      pass_valid <= 1'b0;
      if (halt) begin
        state      <= IDLE;
        reply_data <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (accept) begin
          reply_data <= '0;
          case (state)
            IDLE: begin
              if (word_data[63:56] == CMD_MOVE) begin
                dir_q    <= word_data[0];
                enc_snap <= encoder_count;
                state    <= DUR;
              end else begin
                pass_valid <= 1'b1;
                pass_data  <= word_data;
              end
            end
            DUR: begin
              dur_q <= word_data;
              state <= INC;
            end
            INC: begin
              inc_q      <= word_data;
              reply_data <= enc_snap;
              state      <= INCINC;
            end
            default: state <= IDLE;
          endcase
        end

        if (push) wr_ptr <= wr_ptr + PW'(1);
        rd_ptr     <= rd_ptr_n;
        fifo_count <= count_n;
        // Registered head: the new entry goes straight to the head when nothing older remains.
        if (count_n != '0)
          head_q <= (remain == '0) ? new_entry : mem[rd_ptr_n];

        if (push_req && full && !pop)
          overflow_err <= 1'b1;
        else if (clear_err)
          overflow_err <= 1'b0;
      end
    end
  end

  always_comb begin
    move_valid     = (fifo_count != '0);
    buffer_dtr     = (fifo_count < DEPTH_CNT);
    move_dir       = head_q.dir;
    move_duration  = head_q.dur;
    move_increment = head_q.inc;
    move_incinc    = head_q.incinc;
  end

endmodule

// File: doc/move_word_assembler.md
Name: move_word_assembler

Overview:
- Sits between the SPI word receiver (SPIWord) and the DDA move executor.
- Parses the stream of 64-bit SPI words, assembles each 4-word coordinated-move command into one move descriptor, and queues it in a DEPTH-entry FIFO.
- Presents queued moves to the executor over a valid/ready handshake.
- Replaces edge-clocked word handling and the toggle-latch move buffer with a single-clock design that passes non-move words through and reports buffer status.

Parameters:
- DEPTH, 4: FIFO entries; must be a power of two, at least 2.
- CMD_MOVE, 8'h01: header byte (word bits [63:56]) that starts a coordinated move.

Ports:
- CLK  in  1  system clock
- resetn  in  1  synchronous active-low reset
- word_valid  in  1  one-cycle strobe: word_data holds a newly received SPI word
- word_data  in  64  received word, little-endian, header in [63:56]
- encoder_count  in  64  live signed encoder count
- halt  in  1  synchronous flush request, active high
- clear_err  in  1  clears overflow_err
- reply_data  out  64  word for SPIWord to shift out on the next transfer
- pass_valid  out  1  one-cycle strobe: non-move header word forwarded
- pass_data  out  64  forwarded word
- move_valid  out  1  head FIFO entry valid
- move_ready  in  1  executor accepts the head entry
- move_dir  out  1  head entry direction
- move_duration  out  64  head entry tick count
- move_increment  out  64  head entry signed increment
- move_incinc  out  64  head entry signed increment-of-increment
- fifo_count  out  log2(DEPTH)+1  occupied entries
- buffer_dtr  out  1  1 when fifo_count < DEPTH
- overflow_err  out  1  sticky: a move was dropped because the FIFO was full

Behaviour:
- Reset, while resetn=0 at posedge CLK:
  - state=IDLE; FIFO pointers and fifo_count cleared.
  - reply_data=0, pass_valid=0, pass_data=0, overflow_err=0, move_valid=0.
  - buffer_dtr=1; move_* data outputs=0.
- Parser FSM states: IDLE, DUR, INC, INCINC. It acts only on cycles where word_valid=1.
- Every accepted word (word_valid=1, halt=0): reply_data<=0 unless a rule below overrides it.
- IDLE:
  - If word_data[63:56]==CMD_MOVE: latch dir<=word_data[0], snapshot enc_snap<=encoder_count, go to DUR.
  - Any other header: pass_valid<=1 and pass_data<=word_data for exactly one cycle; stay in IDLE.
- DUR: dur<=word_data; go to INC.
- INC: inc<=word_data; reply_data<=enc_snap; go to INCINC.
- INCINC: push {dir, dur, inc, word_data} into the FIFO; go to IDLE.
  - If the FIFO is full and no pop happens that cycle: drop the entry and set overflow_err<=1.
- In DUR/INC/INCINC, words are always treated as payload, even if their top byte equals CMD_MOVE. There is no header re-sync.
- FIFO:
  - Circular buffer; pointers wrap modulo DEPTH.
  - Outputs are registered from the head entry. There is no fall-through: push at edge N gives move_valid=1 after edge N (visible in cycle N+1).
  - Pop occurs when move_valid && move_ready. The next entry (or move_valid=0) appears after the same edge.
  - Simultaneous push and pop: fifo_count unchanged. This is allowed when full (no overflow) and when count=1.
  - Push with count=0 and move_ready=1 in the same cycle: no pop, because move_valid was 0.
  - move_* data outputs hold the last head value when empty and are don't-care for checking while move_valid=0.
- fifo_count and buffer_dtr update on the same edge as the push/pop.
- halt=1 (priority over word_valid, move_ready and clear_err):
  - Empties the FIFO and returns the FSM to IDLE.
  - Sets reply_data<=0; move_valid=0 next cycle.
  - overflow_err is retained.
- overflow_err: cleared by clear_err=1 when halt=0. Overflow takes priority over clear_err in the same cycle.
- Reset mid-command: any partial move is discarded.
- Arithmetic: no arithmetic on payloads; all 64 bits are stored verbatim.

Test Plan:
- Basic move: words 0x0100_0000_0000_0001, 1000, 0x10, 0x2 with encoder_count=-5.
  - After word 3, reply_data=0xFFFF_FFFF_FFFF_FFFB.
  - After word 4, reply_data=0.
  - Next cycle: move_valid=1, dir=1, duration=1000, increment=0x10, incinc=2, fifo_count=1.
- Fill and overflow (DEPTH=4, move_ready=0): push 5 moves.
  - After 4 pushes, fifo_count=4 and buffer_dtr=0.
  - The 5th move is dropped and overflow_err=1.
  - Pop order returns durations 1,2,3,4.
- Full with simultaneous pop: FIFO full, move_ready=1 on the same cycle as the 4th payload word.
  - fifo_count stays 4; overflow_err stays 0.
  - The new entry is popped last.
- Passthrough: header 0x0A word in IDLE gives pass_valid high for 1 cycle with pass_data equal to the word.
  - FSM stays IDLE; no FIFO change.
  - The same header sent as the DUR payload is stored, not passed.
- Halt: 3 moves queued, partial move in INC, halt pulsed.
  - fifo_count=0, move_valid=0, FSM in IDLE.
  - The next full command queues correctly.
- Reset mid-command: resetn low while in INCINC.
  - All outputs return to reset values.
  - A payload word sent afterwards in IDLE with a non-CMD_MOVE header is passed through, not queued.
